// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producer streams, the stream_mux_rr block and one consumer.
interface stream_mux_rr_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic [SELW-1:0]    out_chan;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, in_last, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_last, out_chan
    );

    modport master (
        output in_data, in_valid, in_last, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_chan
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with fixed or per-packet round-robin select and a one-entry output register.
//   state    | meaning
//   UNLOCKED | between packets; grant comes from sel (mode=0) or round-robin (mode=1)
//   LOCKED   | mid-packet; only lock_chan may be granted until its last beat
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input logic            clk,
    input logic            rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int SELW = $clog2(N);

    typedef enum logic {UNLOCKED, LOCKED} lock_t;

    lock_t            state, state_nxt;
    logic [SELW-1:0]  lock_chan, lock_chan_nxt;
    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  cand;
    logic             grant_valid;
    logic             load_en;
    logic             xfer;
    logic             beat_last;
    logic [WIDTH-1:0] beat_data;
    int               idx;

    assign load_en = !bus.out_valid || bus.out_ready;

    // Round-robin loop runs from farthest to nearest so the nearest valid channel wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        cand        = '0;
        if (state == LOCKED) begin
            grant       = lock_chan;
            grant_valid = bus.in_valid[lock_chan];
        end else if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                grant       = bus.sel;
                grant_valid = bus.in_valid[bus.sel];
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                idx  = (int'(rr_ptr) + k) % N;
                cand = SELW'(idx);
                if (bus.in_valid[cand]) begin
                    grant       = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign xfer      = rst_n && load_en && grant_valid;
    assign beat_data = bus.in_data[grant*WIDTH +: WIDTH];
    assign beat_last = bus.in_last[grant];

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        lock_chan_nxt = lock_chan;
        case (state)
            UNLOCKED: begin
                if (xfer && !beat_last) begin
                    state_nxt     = LOCKED;
                    lock_chan_nxt = grant;
                end
            end
            LOCKED: begin
                if (xfer && beat_last) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= UNLOCKED;
            lock_chan     <= '0;
            rr_ptr        <= SELW'(N - 1);
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_chan  <= '0;
        end else begin
            state     <= state_nxt;
            lock_chan <= lock_chan_nxt;
            // Pointer moves per packet so a long packet does not cost its channel extra turns.
            if (xfer && beat_last) begin
                rr_ptr <= grant;
            end
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= beat_data;
                bus.out_last  <= beat_last;
                bus.out_chan  <= grant;
            end else if (load_en) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: reset vectors, directed corner sequences, random traffic vs a packet-level model.
module tb_stream_mux_rr;
    localparam int N = 4;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.WIDTH(W), .N(N)) bus ();
    stream_mux_rr #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    bit         m_init = 1'b0;
    bit         m_lock = 1'b0;
    int         m_lch  = 0;
    int         m_rr   = N - 1;
    bit         m_ov   = 1'b0;
    bit         m_ol   = 1'b0;
    logic [3:0] m_od   = '0;
    int         m_oc   = 0;

    typedef struct {
        bit         md;
        int         s;
        logic [3:0] v;
        logic [3:0] rdy;
        bit         ov;
        int         ch;
        logic [3:0] dat;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_grant();
        if (m_lock) return bus.in_valid[m_lch] ? m_lch : -1;
        if (!bus.mode) return (int'(bus.sel) < N && bus.in_valid[bus.sel]) ? int'(bus.sel) : -1;
        for (int k = 1; k <= N; k++) begin
            int c = (m_rr + k) % N;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Checks the current cycle against the model, then advances one clock and the model with it.
    task automatic tick();
        int         g;
        bit         load;
        logic [3:0] er;
        #1;
        g    = ref_grant();
        load = !m_ov || bus.out_ready;
        er   = (rst_n && load && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("m_in_ready", 32'(bus.in_ready), 32'(er));
        if (m_init) begin
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("m_out_data", 32'(bus.out_data), 32'(m_od));
                chk("m_out_last", 32'(bus.out_last), 32'(m_ol));
                chk("m_out_chan", 32'(bus.out_chan), 32'(m_oc));
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_init = 1'b1; m_lock = 1'b0; m_lch = 0; m_rr = N - 1;
            m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_oc = 0;
        end else if (er != 4'b0) begin
            m_od = bus.in_data[g*W +: W];
            m_ol = bus.in_last[g];
            m_oc = g;
            m_ov = 1'b1;
            if (m_ol) begin
                m_lock = 1'b0;
                m_rr   = g;
            end else if (!m_lock) begin
                m_lock = 1'b1;
                m_lch  = g;
            end
        end else if (load) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit md, input int s, input logic [3:0] v, input logic [3:0] l, input bit ordy);
        bus.mode      = md;
        bus.sel       = 2'(s);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = ordy;
    endtask

    initial begin
        bus.in_data = '0;
        drive(1'b0, 0, 4'b0000, 4'b0000, 1'b1);

        tbl[0] = '{1'b0, 2, 4'b0100, 4'b0100, 1'b1, 2, 4'hA};
        tbl[1] = '{1'b0, 1, 4'b1101, 4'b0000, 1'b0, 0, 4'h0};
        tbl[2] = '{1'b1, 0, 4'b1111, 4'b0001, 1'b1, 0, 4'h3};
        tbl[3] = '{1'b1, 0, 4'b1100, 4'b0100, 1'b1, 2, 4'hA};
        tbl[4] = '{1'b1, 0, 4'b1000, 4'b1000, 1'b1, 3, 4'hD};
        tbl[5] = '{1'b0, 3, 4'b1111, 4'b1000, 1'b1, 3, 4'hD};
        tbl[6] = '{1'b1, 0, 4'b0000, 4'b0000, 1'b0, 0, 4'h0};
        tbl[7] = '{1'b0, 0, 4'b0001, 4'b0001, 1'b1, 0, 4'h3};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_chan", 32'(bus.out_chan), 32'd0);
            bus.in_data = 16'hDA53;
            drive(tbl[i].md, tbl[i].s, tbl[i].v, 4'b1111, 1'b1);
            #1;
            chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].rdy));
            tick();
            chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk("tbl_out_chan", 32'(bus.out_chan), 32'(tbl[i].ch));
                chk("tbl_out_data", 32'(bus.out_data), 32'(tbl[i].dat));
                chk("tbl_out_last", 32'(bus.out_last), 32'd1);
            end
        end

        // Round-robin over four single-beat producers.
        do_reset();
        bus.in_data = 16'h3210;
        drive(1'b1, 0, 4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_chan", 32'(bus.out_chan), 32'(i % 4));
            chk("rr_valid", 32'(bus.out_valid), 32'd1);
        end

        // Three-beat packet on ch1 holds the lock against ch0/ch2.
        do_reset();
        bus.in_data = 16'h3210;
        drive(1'b1, 0, 4'b0001, 4'b0001, 1'b1);
        tick();
        chk("lk_chan0", 32'(bus.out_chan), 32'd0);
        drive(1'b1, 0, 4'b0111, 4'b0101, 1'b1);
        tick();
        chk("lk_beat1", 32'(bus.out_chan), 32'd1);
        tick();
        chk("lk_beat2", 32'(bus.out_chan), 32'd1);
        bus.in_last = 4'b0111;
        tick();
        chk("lk_beat3", 32'(bus.out_chan), 32'd1);
        chk("lk_last", 32'(bus.out_last), 32'd1);
        drive(1'b1, 0, 4'b0101, 4'b0101, 1'b1);
        tick();
        chk("lk_next2", 32'(bus.out_chan), 32'd2);
        tick();
        chk("lk_next0", 32'(bus.out_chan), 32'd0);

        // Backpressure holds the beat, then one beat per cycle resumes.
        do_reset();
        bus.in_data = 16'hD000;
        drive(1'b0, 3, 4'b1000, 4'b1000, 1'b1);
        tick();
        chk("bp_first", 32'(bus.out_data), 32'hD);
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h7000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
            tick();
            chk("bp_hold_data", 32'(bus.out_data), 32'hD);
            chk("bp_hold_chan", 32'(bus.out_chan), 32'd3);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = {4'(7 + i), 12'h000};
            tick();
            chk("bp_stream", 32'(bus.out_data), 32'(7 + i));
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
        end

        // Fixed mode: unselected-valid gives no grant; sel change mid-packet is ignored.
        do_reset();
        bus.in_data = 16'h3210;
        drive(1'b0, 0, 4'b1101, 4'b1111, 1'b1);
        tick();
        drive(1'b0, 1, 4'b1101, 4'b1111, 1'b1);
        #1;
        chk("fx_nogrant", 32'(bus.in_ready), 32'd0);
        tick();
        chk("fx_drain", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 1, 4'b0010, 4'b0000, 1'b1);
        tick();
        chk("fx_lock", 32'(bus.out_chan), 32'd1);
        drive(1'b0, 3, 4'b1010, 4'b0000, 1'b1);
        tick();
        chk("fx_hold1", 32'(bus.out_chan), 32'd1);
        bus.in_last = 4'b0010;
        tick();
        chk("fx_hold2", 32'(bus.out_chan), 32'd1);
        chk("fx_last", 32'(bus.out_last), 32'd1);
        tick();
        chk("fx_sel3", 32'(bus.out_chan), 32'd3);

        // Reset while locked on ch2 with a beat held.
        do_reset();
        bus.in_data = 16'h3210;
        drive(1'b1, 0, 4'b0100, 4'b0000, 1'b0);
        tick();
        chk("mr_locked", 32'(bus.out_chan), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_chan", 32'(bus.out_chan), 32'd0);
        drive(1'b1, 0, 4'b1111, 4'b1111, 1'b1);
        tick();
        chk("mr_rr0", 32'(bus.out_chan), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rst_n         = ($urandom_range(0, 59) != 0);
            bus.mode      = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_last   = 4'($urandom);
            bus.in_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
